// File: rtl/clint_pkg.sv
// Shared constants, register decode and byte-lane merge for the core-local interruptor.
package clint_pkg;

    localparam logic [31:0] MSIP_OFF        = 32'h0000_0000;
    localparam logic [31:0] MTIMECMP_LO_OFF = 32'h0000_4000;
    localparam logic [31:0] MTIMECMP_HI_OFF = 32'h0000_4004;
    localparam logic [31:0] MTIME_LO_OFF    = 32'h0000_BFF8;
    localparam logic [31:0] MTIME_HI_OFF    = 32'h0000_BFFC;

    localparam logic [30:0] CLINT_MSI_CODE = 31'd3;
    localparam logic [30:0] CLINT_MTI_CODE = 31'd7;

    localparam int unsigned MIE_MSIE_BIT    = 3;
    localparam int unsigned MIE_MTIE_BIT    = 7;
    localparam int unsigned MSTATUS_MIE_BIT = 3;

    typedef enum logic [2:0] {
        RegNone,
        RegMsip,
        RegCmpLo,
        RegCmpHi,
        RegTimeLo,
        RegTimeHi
    } reg_sel_e;

    function automatic reg_sel_e decode_offset(input logic [31:0] off);
        reg_sel_e r;
        case (off)
            MSIP_OFF:        r = RegMsip;
            MTIMECMP_LO_OFF: r = RegCmpLo;
            MTIMECMP_HI_OFF: r = RegCmpHi;
            MTIME_LO_OFF:    r = RegTimeLo;
            MTIME_HI_OFF:    r = RegTimeHi;
            default:         r = RegNone;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*8 +: 8] = sel[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/clint_if.sv
// Wishbone B4 classic slave port bundle for the CLINT.
interface clint_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/clint_timer.sv
// Prescaled 64-bit mtime counter; per-half bus loads win over a same-cycle tick.
module clint_timer #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_lo,
    input  logic        load_hi,
    input  logic [31:0] load_val,
    output logic [63:0] mtime
);
    localparam logic [15:0] TICK_MAX = 16'(TICK_DIV - 1);

    logic [15:0] presc_q, presc_d;
    logic [63:0] mtime_q, mtime_d;
    logic        tick;

    assign tick  = (presc_q == TICK_MAX);
    assign mtime = mtime_q;

    always_comb begin
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
    end

    // A load freezes the other half too: no carry is applied on a load cycle.
    always_comb begin
        mtime_d = mtime_q;
        if (load_lo) begin
            mtime_d[31:0] = load_val;
        end else if (load_hi) begin
            mtime_d[63:32] = load_val;
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            mtime_q <= '0;
        end else begin
            presc_q <= presc_d;
            mtime_q <= mtime_d;
        end
    end
endmodule

// File: rtl/clint.sv
// Core-local interruptor: Wishbone register file for msip/mtime/mtimecmp and the
// registered interrupt request towards the core's MEM stage.
module clint
    import clint_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    clint_if.slave      wb,
    input  logic [31:0] latest_mie,
    input  logic [31:0] latest_mstatus,
    output logic        interrupt_clint,
    output logic [30:0] exception_code_clint
);
    localparam logic [31:0] ADDR_MASK =
        (ADDR_W >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << ADDR_W) - 64'd1);

    logic        ack_q, accept, wr_en, rd_en;
    logic [31:0] dat_q, dat_d, rdata, offset;
    reg_sel_e    sel;
    logic        msip_q, msip_d;
    logic [63:0] cmp_q, cmp_d, mtime;
    logic        load_lo, load_hi;
    logic [31:0] load_val;
    logic        sw_req, tm_req, irq_q, irq_d;
    logic [30:0] code_q, code_d;
    logic        unused_bits;

    assign offset = wb.wb_adr_i & ADDR_MASK & 32'hFFFF_FFFC;
    assign sel    = decode_offset(offset);
    // Blocking on ack_q gives the one-cycle gap between back-to-back acks.
    assign accept = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
    assign wr_en  = accept & wb.wb_we_i;
    assign rd_en  = accept & ~wb.wb_we_i;

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;

    always_comb begin
        rdata = '0;
        unique case (sel)
            RegMsip:   rdata = {31'd0, msip_q};
            RegCmpLo:  rdata = cmp_q[31:0];
            RegCmpHi:  rdata = cmp_q[63:32];
            RegTimeLo: rdata = mtime[31:0];
            RegTimeHi: rdata = mtime[63:32];
            RegNone:   rdata = '0;
        endcase
        dat_d = rd_en ? rdata : dat_q;
    end

    always_comb begin
        msip_d   = msip_q;
        cmp_d    = cmp_q;
        load_lo  = 1'b0;
        load_hi  = 1'b0;
        load_val = merge_bytes((sel == RegTimeHi) ? mtime[63:32] : mtime[31:0],
                               wb.wb_dat_i, wb.wb_sel_i);
        if (wr_en) begin
            unique case (sel)
                RegMsip:   if (wb.wb_sel_i[0]) msip_d = wb.wb_dat_i[0];
                RegCmpLo:  cmp_d[31:0]  = merge_bytes(cmp_q[31:0], wb.wb_dat_i, wb.wb_sel_i);
                RegCmpHi:  cmp_d[63:32] = merge_bytes(cmp_q[63:32], wb.wb_dat_i, wb.wb_sel_i);
                RegTimeLo: load_lo = 1'b1;
                RegTimeHi: load_hi = 1'b1;
                RegNone:   ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q  <= 1'b0;
            dat_q  <= '0;
            msip_q <= 1'b0;
            cmp_q  <= '1;
        end else begin
            ack_q  <= accept;
            dat_q  <= dat_d;
            msip_q <= msip_d;
            cmp_q  <= cmp_d;
        end
    end

    clint_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load_lo  (load_lo),
        .load_hi  (load_hi),
        .load_val (load_val),
        .mtime    (mtime)
    );

    always_comb begin
        sw_req = msip_q & latest_mie[MIE_MSIE_BIT];
        tm_req = (mtime >= cmp_q) & latest_mie[MIE_MTIE_BIT];
        irq_d  = latest_mstatus[MSTATUS_MIE_BIT] & (sw_req | tm_req);
        code_d = sw_req ? CLINT_MSI_CODE : (tm_req ? CLINT_MTI_CODE : 31'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q  <= 1'b0;
            code_q <= '0;
        end else begin
            irq_q  <= irq_d;
            code_q <= code_d;
        end
    end

    assign interrupt_clint      = irq_q;
    assign exception_code_clint = code_q;

    assign unused_bits = ^{latest_mie[31:8], latest_mie[6:4], latest_mie[2:0],
                           latest_mstatus[31:4], latest_mstatus[2:0]};
endmodule

// File: tb/tb_clint.sv
// Directed self-checking bench for clint with TICK_DIV = 4.
module tb_clint;
    localparam int TB_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] latest_mie = '0;
    logic [31:0] latest_mstatus = '0;
    logic        interrupt_clint;
    logic [30:0] exception_code_clint;

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;

    logic [31:0] rdat;
    int          acc, w1, w2, tgt;

    clint_if wb ();

    clint #(
        .TICK_DIV (TB_DIV),
        .ADDR_W   (16)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .wb                   (wb),
        .latest_mie           (latest_mie),
        .latest_mstatus       (latest_mstatus),
        .interrupt_clint      (interrupt_clint),
        .exception_code_clint (exception_code_clint)
    );

    always #5 clk = ~clk;

    // Edge k (1-based after reset release) is a tick edge when k % TB_DIV == 0.
    always @(posedge clk) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // mtime value seen by a read accepted at rd_edge, given base loaded at wr_edge.
    function automatic logic [63:0] mtime_model(input logic [63:0] base, input int wr_edge,
                                                input int rd_edge);
        return base + 64'((rd_edge - 1) / TB_DIV - wr_edge / TB_DIV);
    endfunction

    task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                        input logic [3:0] sel, output logic [31:0] rd, output int acc_edge);
        int n;
        @(negedge clk);
        wb.wb_adr_i = adr;
        wb.wb_we_i  = we;
        wb.wb_dat_i = dat;
        wb.wb_sel_i = sel;
        wb.wb_cyc_i = 1'b1;
        wb.wb_stb_i = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!wb.wb_ack_o && n < 8);
        check("ack", 64'(wb.wb_ack_o), 64'd1);
        rd       = wb.wb_dat_o;
        acc_edge = edge_cnt;
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        wb.wb_we_i  = 1'b0;
        @(posedge clk);
        #1;
        check("ack_width", 64'(wb.wb_ack_o), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        wb.wb_adr_i = '0;
        wb.wb_dat_i = '0;
        wb.wb_we_i  = 1'b0;
        wb.wb_sel_i = 4'hF;
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 64'(wb.wb_ack_o), 64'd0);
        check("rst_dat", 64'(wb.wb_dat_o), 64'd0);
        check("rst_irq", 64'(interrupt_clint), 64'd0);
        check("rst_code", 64'(exception_code_clint), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset contents
        xfer(32'h0000_0000, 1'b0, 0, 4'hF, rdat, acc);
        check("rd_msip", 64'(rdat), 64'd0);
        xfer(32'h0000_4000, 1'b0, 0, 4'hF, rdat, acc);
        check("rd_cmp_lo", 64'(rdat), 64'hFFFF_FFFF);
        xfer(32'h0000_4004, 1'b0, 0, 4'hF, rdat, acc);
        check("rd_cmp_hi", 64'(rdat), 64'hFFFF_FFFF);
        xfer(32'h0000_BFF8, 1'b0, 0, 4'hF, rdat, acc);
        check("rd_time_lo", 64'(rdat), 64'(mtime_model(64'd0, 0, acc) & 64'hFFFF_FFFF));
        xfer(32'h0000_BFFC, 1'b0, 0, 4'hF, rdat, acc);
        check("rd_time_hi", 64'(rdat), 64'd0);
        check("irq_idle", 64'(interrupt_clint), 64'd0);

        // Software interrupt: request registered one edge after msip updates
        @(negedge clk);
        latest_mie     = 32'h08;
        latest_mstatus = 32'h08;
        wb.wb_adr_i = 32'h0000_0000;
        wb.wb_we_i  = 1'b1;
        wb.wb_dat_i = 32'h1;
        wb.wb_sel_i = 4'hF;
        wb.wb_cyc_i = 1'b1;
        wb.wb_stb_i = 1'b1;
        @(posedge clk);
        #1;
        check("sw_wr_ack", 64'(wb.wb_ack_o), 64'd1);
        check("sw_irq_early", 64'(interrupt_clint), 64'd0);
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        wb.wb_we_i  = 1'b0;
        @(posedge clk);
        #1;
        check("sw_irq", 64'(interrupt_clint), 64'd1);
        check("sw_code", 64'(exception_code_clint), 64'd3);
        xfer(32'h0000_0000, 1'b1, 32'h0, 4'hF, rdat, acc);
        check("sw_clear", 64'(interrupt_clint), 64'd0);

        // Timer interrupt at mtime == 10
        @(negedge clk);
        latest_mie = 32'h80;
        xfer(32'h0000_4000, 1'b1, 32'd10, 4'hF, rdat, acc);
        xfer(32'h0000_BFF8, 1'b1, 32'd0, 4'hF, rdat, w1);
        tgt = TB_DIV * (w1 / TB_DIV + 10) + 1;
        xfer(32'h0000_4004, 1'b1, 32'd0, 4'hF, rdat, acc);
        for (int i = 0; i < 200; i++) begin
            if (interrupt_clint) break;
            @(posedge clk);
            #1;
        end
        check("tm_edge", 64'(edge_cnt), 64'(tgt));
        check("tm_irq", 64'(interrupt_clint), 64'd1);
        check("tm_code", 64'(exception_code_clint), 64'd7);
        xfer(32'h0000_4004, 1'b1, 32'd1, 4'hF, rdat, acc);
        check("tm_clear", 64'(interrupt_clint), 64'd0);

        // Carry from low into high half
        xfer(32'h0000_BFFC, 1'b1, 32'd0, 4'hF, rdat, w1);
        xfer(32'h0000_BFF8, 1'b1, 32'hFFFF_FFFF, 4'hF, rdat, w2);
        repeat (TB_DIV) @(posedge clk);
        xfer(32'h0000_BFFC, 1'b0, 0, 4'hF, rdat, acc);
        check("carry_hi", 64'(rdat), 64'd1);
        check("carry_hi_model", 64'(rdat), mtime_model(64'h0_FFFF_FFFF, w2, acc) >> 32);
        xfer(32'h0000_BFF8, 1'b0, 0, 4'hF, rdat, acc);
        check("carry_lo", 64'(rdat),
              mtime_model(64'h0_FFFF_FFFF, w2, acc) & 64'hFFFF_FFFF);

        // Load on a tick edge suppresses the increment
        #1;
        while ((edge_cnt + 1) % TB_DIV != 0) begin
            @(posedge clk);
            #1;
        end
        xfer(32'h0000_BFF8, 1'b1, 32'h1234_5678, 4'hF, rdat, w1);
        xfer(32'h0000_BFF8, 1'b0, 0, 4'hF, rdat, acc);
        check("tick_load", 64'(rdat), 64'h1234_5678);

        // Both pending: software wins; MIE gates the request but not the code
        @(negedge clk);
        latest_mie = 32'h88;
        xfer(32'h0000_0000, 1'b1, 32'h1, 4'hF, rdat, acc);
        check("both_irq", 64'(interrupt_clint), 64'd1);
        check("both_code", 64'(exception_code_clint), 64'd3);
        @(negedge clk);
        latest_mstatus = 32'h0;
        @(posedge clk);
        #1;
        check("mie_off_irq", 64'(interrupt_clint), 64'd0);
        check("mie_off_code", 64'(exception_code_clint), 64'd3);
        xfer(32'h0000_0000, 1'b0, 0, 4'hF, rdat, acc);
        check("msip_held", 64'(rdat), 64'd1);

        // Byte lanes, address aliasing, unmapped offsets
        xfer(32'h0000_4000, 1'b1, 32'hAABB_CCDD, 4'b0010, rdat, acc);
        xfer(32'h0000_4000, 1'b0, 0, 4'hF, rdat, acc);
        check("byte_lane", 64'(rdat), 64'h0000_CC0A);
        xfer(32'h0001_4000, 1'b0, 0, 4'hF, rdat, acc);
        check("alias", 64'(rdat), 64'h0000_CC0A);
        xfer(32'h0000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, rdat, acc);
        check("dat_hold", 64'(wb.wb_dat_o), 64'h0000_CC0A);
        xfer(32'h0000_1000, 1'b0, 0, 4'hF, rdat, acc);
        check("unmapped", 64'(rdat), 64'd0);

        // Held strobe: one ack every two cycles
        @(negedge clk);
        wb.wb_adr_i = 32'h0000_0000;
        wb.wb_we_i  = 1'b0;
        wb.wb_cyc_i = 1'b1;
        wb.wb_stb_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("held_ack", 64'(wb.wb_ack_o), (i % 2 == 0) ? 64'd1 : 64'd0);
        end
        check("held_dat", 64'(wb.wb_dat_o), 64'd1);
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
